// File: rtl/ddr2_arbiter.sv
// ddr2_arbiter: round-robin owner of the DDR2 controller user interface shared
// by the test harness (requester 0) and the bus bridge (requester 1). Every
// read is tagged with its issuer so returning beats are steered correctly.
module ddr2_arbiter #(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned MASK_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned BEATS_PER_READ = 2,
   parameter int unsigned TAG_DEPTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [1:0]                m_request_i,
   output logic [1:0]                m_granted_o,
   input  logic [1:0]                m_rd_wr_n_i,
   input  logic [61:0]               m_addr_i,
   input  logic [4*DATA_WIDTH-1:0]   m_data_i,
   input  logic [4*MASK_WIDTH-1:0]   m_mask_i,
   input  logic [1:0]                m_af_we_i,
   input  logic [1:0]                m_df_we_i,
   output logic [1:0]                m_af_afull_o,
   output logic [1:0]                m_df_afull_o,
   output logic [2*DATA_WIDTH-1:0]   m_data_o,
   output logic [1:0]                m_dvalid_o,
   output logic                      ddr_rd_wr_n_o,
   output logic [30:0]               ddr_addr_o,
   output logic [2*DATA_WIDTH-1:0]   ddr_data_o,
   output logic [2*MASK_WIDTH-1:0]   ddr_mask_o,
   output logic                      ddr_af_we_o,
   output logic                      ddr_df_we_o,
   input  logic                      ddr_af_afull_i,
   input  logic                      ddr_df_afull_i,
   input  logic [2*DATA_WIDTH-1:0]   ddr_data_i,
   input  logic                      ddr_dvalid_i,
   input  logic                      ddr_phy_rdy_i,
   output logic                      tag_err_o
);

   localparam int unsigned DW2 = 2 * DATA_WIDTH;
   localparam int unsigned MW2 = 2 * MASK_WIDTH;
   localparam int unsigned AW  = $clog2(TAG_DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned BW  = (BEATS_PER_READ > 1) ? $clog2(BEATS_PER_READ) : 1;

   localparam logic [CW-1:0] TAG_FULL  = CW'(TAG_DEPTH);
   localparam logic [CW-1:0] TAG_AFULL = CW'(TAG_DEPTH - 2);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_READ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          last_owner;
   logic          owner;
   logic          owned;

   logic          tag_mem [TAG_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] tag_count;
   logic [BW-1:0] beat;
   logic          tag_err;

   logic          tag_empty;
   logic          tag_full;
   logic          tag_head;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          beat_valid;

   // State register and record of who was granted last.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state <= state_next;
         if (state == IDLE && state_next == OWN0) last_owner <= 1'b0;
         if (state == IDLE && state_next == OWN1) last_owner <= 1'b1;
      end
   end

   // Next-state: the requester that did not own last time is preferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (ddr_phy_rdy_i) begin
               if (m_request_i[~last_owner])
                  state_next = last_owner ? OWN0 : OWN1;
               else if (m_request_i[last_owner])
                  state_next = last_owner ? OWN1 : OWN0;
            end
         end
         OWN0:    if (!m_request_i[0]) state_next = IDLE;
         OWN1:    if (!m_request_i[1]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Command path: combinational mux from the current owner, zeroed when idle.
   always_comb begin
      m_granted_o   = {state == OWN1, state == OWN0};
      owned         = (state == OWN0) || (state == OWN1);
      owner         = (state == OWN1);
      ddr_af_we_o   = 1'b0;
      ddr_df_we_o   = 1'b0;
      ddr_rd_wr_n_o = 1'b1;
      ddr_addr_o    = '0;
      ddr_data_o    = '0;
      ddr_mask_o    = '0;
      if (owned) begin
         ddr_af_we_o   = m_af_we_i[owner];
         ddr_df_we_o   = m_df_we_i[owner];
         ddr_rd_wr_n_o = m_rd_wr_n_i[owner];
         ddr_addr_o    = owner ? m_addr_i[61:31] : m_addr_i[30:0];
         ddr_data_o    = owner ? m_data_i[2*DW2-1:DW2] : m_data_i[DW2-1:0];
         ddr_mask_o    = owner ? m_mask_i[2*MW2-1:MW2] : m_mask_i[MW2-1:0];
      end
   end

   // Tag FIFO control, read steering and back-pressure.
   always_comb begin
      tag_empty    = (tag_count == '0);
      tag_full     = (tag_count == TAG_FULL);
      tag_head     = tag_mem[rd_ptr];
      push_req     = ddr_af_we_o & ddr_rd_wr_n_o;
      beat_valid   = ddr_dvalid_i & ~tag_empty;
      pop          = beat_valid & (beat == BEAT_LAST);
      // A full FIFO still accepts a tag when the head leaves in the same cycle.
      push         = push_req & (~tag_full | pop);
      m_data_o     = ddr_data_i;
      m_dvalid_o   = {beat_valid & tag_head, beat_valid & ~tag_head};
      m_af_afull_o = ~m_granted_o | {2{ddr_af_afull_i | (tag_count >= TAG_AFULL)}};
      m_df_afull_o = ~m_granted_o | {2{ddr_df_afull_i}};
      tag_err_o    = tag_err;
   end

   // Tag storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= owner;
   end

   // Pointers, occupancy, beat counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tag_count <= '0;
         beat      <= '0;
         tag_err   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   tag_count <= tag_count + CW'(1);
            2'b01:   tag_count <= tag_count - CW'(1);
            default: tag_count <= tag_count;
         endcase
         if (beat_valid) beat <= pop ? '0 : beat + BW'(1);
         if ((ddr_dvalid_i & tag_empty) | (push_req & tag_full & ~pop))
            tag_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr2_arbiter.sv
// tb_ddr2_arbiter: directed test-plan steps followed by randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_ddr2_arbiter;

   localparam int DW = 64;
   localparam int MW = 8;
   localparam int B  = 2;
   localparam int TD = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        m_request_i;
   logic [1:0]        m_granted_o;
   logic [1:0]        m_rd_wr_n_i;
   logic [61:0]       m_addr_i;
   logic [4*DW-1:0]   m_data_i;
   logic [4*MW-1:0]   m_mask_i;
   logic [1:0]        m_af_we_i;
   logic [1:0]        m_df_we_i;
   logic [1:0]        m_af_afull_o;
   logic [1:0]        m_df_afull_o;
   logic [2*DW-1:0]   m_data_o;
   logic [1:0]        m_dvalid_o;
   logic              ddr_rd_wr_n_o;
   logic [30:0]       ddr_addr_o;
   logic [2*DW-1:0]   ddr_data_o;
   logic [2*MW-1:0]   ddr_mask_o;
   logic              ddr_af_we_o;
   logic              ddr_df_we_o;
   logic              ddr_af_afull_i;
   logic              ddr_df_afull_i;
   logic [2*DW-1:0]   ddr_data_i;
   logic              ddr_dvalid_i;
   logic              ddr_phy_rdy_i;
   logic              tag_err_o;

   ddr2_arbiter #(
      .DATA_WIDTH(DW),
      .MASK_WIDTH(MW),
      .BEATS_PER_READ(B),
      .TAG_DEPTH(TD)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .m_request_i(m_request_i), .m_granted_o(m_granted_o),
      .m_rd_wr_n_i(m_rd_wr_n_i), .m_addr_i(m_addr_i),
      .m_data_i(m_data_i), .m_mask_i(m_mask_i),
      .m_af_we_i(m_af_we_i), .m_df_we_i(m_df_we_i),
      .m_af_afull_o(m_af_afull_o), .m_df_afull_o(m_df_afull_o),
      .m_data_o(m_data_o), .m_dvalid_o(m_dvalid_o),
      .ddr_rd_wr_n_o(ddr_rd_wr_n_o), .ddr_addr_o(ddr_addr_o),
      .ddr_data_o(ddr_data_o), .ddr_mask_o(ddr_mask_o),
      .ddr_af_we_o(ddr_af_we_o), .ddr_df_we_o(ddr_df_we_o),
      .ddr_af_afull_i(ddr_af_afull_i), .ddr_df_afull_i(ddr_df_afull_i),
      .ddr_data_i(ddr_data_i), .ddr_dvalid_i(ddr_dvalid_i),
      .ddr_phy_rdy_i(ddr_phy_rdy_i), .tag_err_o(tag_err_o)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner (2 = nobody), last owner, outstanding read tags.
   int  m_own  = 2;
   int  m_last = 1;
   bit  tagq[$];
   int  m_beat = 0;
   bit  m_err  = 1'b0;

   logic [1:0]      e_grant, e_af_afull, e_df_afull, e_dvalid;
   logic            e_af_we, e_df_we, e_rdwr;
   logic [30:0]     e_addr;
   logic [2*DW-1:0] e_data;
   logic [2*MW-1:0] e_mask;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_outputs();
      e_grant = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
      if (m_own < 2) begin
         e_af_we = m_af_we_i[m_own];
         e_df_we = m_df_we_i[m_own];
         e_rdwr  = m_rd_wr_n_i[m_own];
         e_addr  = m_addr_i[31*m_own +: 31];
         e_data  = m_data_i[2*DW*m_own +: 2*DW];
         e_mask  = m_mask_i[2*MW*m_own +: 2*MW];
      end else begin
         e_af_we = 1'b0;
         e_df_we = 1'b0;
         e_rdwr  = 1'b1;
         e_addr  = '0;
         e_data  = '0;
         e_mask  = '0;
      end
      for (int i = 0; i < 2; i++) begin
         e_af_afull[i] = !e_grant[i] || ddr_af_afull_i || (tagq.size() >= TD - 2);
         e_df_afull[i] = !e_grant[i] || ddr_df_afull_i;
      end
      e_dvalid = 2'b00;
      if (ddr_dvalid_i && tagq.size() > 0) e_dvalid[tagq[0]] = 1'b1;
   endtask

   task automatic check_all();
      model_outputs();
      chk("grant",     m_granted_o,   e_grant);
      chk("af_we",     ddr_af_we_o,   e_af_we);
      chk("df_we",     ddr_df_we_o,   e_df_we);
      chk("rd_wr_n",   ddr_rd_wr_n_o, e_rdwr);
      chk("addr",      ddr_addr_o,    e_addr);
      chk("wdata",     ddr_data_o,    e_data);
      chk("mask",      ddr_mask_o,    e_mask);
      chk("af_afull",  m_af_afull_o,  e_af_afull);
      chk("df_afull",  m_df_afull_o,  e_df_afull);
      chk("dvalid",    m_dvalid_o,    e_dvalid);
      chk("rdata",     m_data_o,      ddr_data_i);
      chk("tag_err",   tag_err_o,     m_err);
   endtask

   task automatic model_clock();
      bit pushv, popv;
      int sz;
      model_outputs();
      if (!reset_n) begin
         m_own = 2; m_last = 1; tagq.delete(); m_beat = 0; m_err = 1'b0;
         return;
      end
      pushv = e_af_we && e_rdwr;
      popv  = 1'b0;
      if (ddr_dvalid_i) begin
         if (tagq.size() == 0) m_err = 1'b1;
         else if (m_beat == B - 1) begin popv = 1'b1; m_beat = 0; end
         else m_beat++;
      end
      sz = tagq.size();
      if (popv) void'(tagq.pop_front());
      if (pushv) begin
         if (sz == TD && !popv) m_err = 1'b1;
         else tagq.push_back(m_own == 1);
      end
      if (m_own == 2) begin
         if (ddr_phy_rdy_i) begin
            if (m_request_i[1 - m_last]) begin m_own = 1 - m_last; m_last = m_own; end
            else if (m_request_i[m_last]) m_own = m_last;
         end
      end else if (!m_request_i[m_own]) m_own = 2;
   endtask

   // One clock cycle: check on the falling edge, advance the model on the rising edge.
   task automatic cyc();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   // Directed test-plan steps followed by randomized traffic.
   initial begin
      reset_n = 1'b0; m_request_i = 2'b11; m_rd_wr_n_i = 2'b00; m_addr_i = '0;
      m_data_i = '0; m_mask_i = '0; m_af_we_i = 2'b00; m_df_we_i = 2'b00;
      ddr_af_afull_i = 1'b0; ddr_df_afull_i = 1'b0; ddr_data_i = '0;
      ddr_dvalid_i = 1'b0; ddr_phy_rdy_i = 1'b1;
      @(posedge clk); #1;

      // Reset held with both requests high.
      for (int i = 0; i < 4; i++) begin
         chk("rst_grant", m_granted_o, 2'b00);
         cyc();
      end
      chk("rst_tag_err", tag_err_o, 1'b0);
      reset_n = 1'b1; #1;
      chk("rst_release_idle", m_granted_o, 2'b00);
      cyc();
      chk("first_grant", m_granted_o, 2'b01);

      // Round-robin handover.
      for (int i = 0; i < 3; i++) cyc();
      m_request_i = 2'b10; #1;
      chk("rr_hold0", m_granted_o, 2'b01);
      cyc();
      chk("rr_gap0", m_granted_o, 2'b00);
      cyc();
      chk("rr_grant1", m_granted_o, 2'b10);
      m_request_i = 2'b01;
      cyc();
      chk("rr_gap1", m_granted_o, 2'b00);
      cyc();
      chk("rr_grant0", m_granted_o, 2'b01);
      m_request_i = 2'b00;
      cyc();

      // Gating of a non-owner enable.
      m_request_i = 2'b10;
      cyc();
      chk("gate_grant", m_granted_o, 2'b10);
      m_af_we_i = 2'b01; m_rd_wr_n_i = 2'b11;
      m_addr_i = {31'h55, 31'h100}; #1;
      chk("gate_af_we", ddr_af_we_o, 1'b0);
      chk("gate_addr", ddr_addr_o, 31'h55);
      cyc();
      m_af_we_i = 2'b00; m_request_i = 2'b00;
      cyc();

      // Read steering across an ownership change.
      m_request_i = 2'b01;
      cyc();
      chk("steer_grant0", m_granted_o, 2'b01);
      m_af_we_i = 2'b01;
      m_addr_i = {31'h0, 31'h200}; cyc();
      m_addr_i = {31'h0, 31'h240}; cyc();
      m_af_we_i = 2'b00; m_request_i = 2'b00;
      cyc();
      m_request_i = 2'b10;
      cyc();
      chk("steer_grant1", m_granted_o, 2'b10);
      m_af_we_i = 2'b10; m_addr_i = {31'h300, 31'h0};
      cyc();
      m_af_we_i = 2'b00; m_request_i = 2'b00;
      cyc();
      ddr_dvalid_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ddr_data_i = {$urandom(), $urandom(), $urandom(), $urandom()}; #1;
         chk("steer_beat", m_dvalid_o, (k < 4) ? 2'b01 : 2'b10);
         cyc();
      end
      ddr_dvalid_i = 1'b0;

      // Tag-FIFO back-pressure.
      m_request_i = 2'b01;
      cyc();
      chk("bp_grant", m_granted_o, 2'b01);
      m_af_we_i = 2'b01; m_rd_wr_n_i = 2'b01;
      for (int k = 0; k < 14; k++) begin
         m_addr_i = 62'(k * 64); #1;
         chk("bp_afull_low", m_af_afull_o[0], 1'b0);
         cyc();
      end
      m_af_we_i = 2'b00; #1;
      chk("bp_afull_at14", m_af_afull_o[0], 1'b1);
      ddr_dvalid_i = 1'b1;
      cyc(); cyc();
      ddr_dvalid_i = 1'b0; #1;
      chk("bp_afull_release", m_af_afull_o[0], 1'b0);
      ddr_dvalid_i = 1'b1;
      for (int k = 0; k < 26; k++) cyc();
      ddr_dvalid_i = 1'b0; m_request_i = 2'b00;
      cyc();

      // Data with nothing outstanding.
      ddr_dvalid_i = 1'b1; #1;
      chk("err_dvalid", m_dvalid_o, 2'b00);
      chk("err_before", tag_err_o, 1'b0);
      cyc();
      ddr_dvalid_i = 1'b0;
      chk("err_set", tag_err_o, 1'b1);
      for (int k = 0; k < 3; k++) cyc();
      chk("err_sticky", tag_err_o, 1'b1);
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      chk("err_cleared", tag_err_o, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         reset_n = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 7) == 0) m_request_i[i] = ~m_request_i[i];
            m_af_we_i[i] = ($urandom_range(0, 3) == 0);
            m_df_we_i[i] = ($urandom_range(0, 3) == 0);
         end
         m_rd_wr_n_i    = 2'($urandom());
         m_addr_i       = 62'({$urandom(), $urandom()});
         m_data_i       = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
         m_mask_i       = $urandom();
         ddr_data_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
         ddr_phy_rdy_i  = ($urandom_range(0, 9) != 0);
         ddr_af_afull_i = ($urandom_range(0, 3) == 0);
         ddr_df_afull_i = ($urandom_range(0, 3) == 0);
         ddr_dvalid_i   = (tagq.size() > 0) ? ($urandom_range(0, 1) == 1)
                                            : ($urandom_range(0, 49) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ddr2_arbiter.md
# ddr2_arbiter

Two-port arbiter that shares the single DDR2 controller user interface between two requesters: the DDR2 test harness and the bus bridge. It grants ownership of the command and write-data FIFOs round-robin through the existing `ddr_request_o`/`ddr_granted_i` handshake. It tags every issued read so that returning read data is steered to the requester that issued it, even after ownership has moved on. It sits between the requesters and the DDR2 controller, in the `clk` domain.

## Interface
- `DATA_WIDTH`, 64: DDR data width; user data buses are `2*DATA_WIDTH`.
- `MASK_WIDTH`, `DATA_WIDTH/8`: mask bits per half-word; user masks are `2*MASK_WIDTH`.
- `BEATS_PER_READ`, 2: `ddr_dvalid_i` cycles returned per read command.
- `TAG_DEPTH`, 16: maximum outstanding reads; must be a power of 2 and ≥4.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `m_request_i`, in, 2: per-requester request; bit i = requester i.
- `m_granted_o`, out, 2: per-requester grant, one-hot or zero.
- `m_rd_wr_n_i`, in, 2: read/not-write, one bit per requester.
- `m_addr_i`, in, 62: 31-bit addresses; requester i occupies `[31i+30:31i]`.
- `m_data_i`, in, `4*DATA_WIDTH`: write data, packed the same way.
- `m_mask_i`, in, `4*MASK_WIDTH`: write masks, packed the same way.
- `m_af_we_i`, in, 2: address FIFO write enables.
- `m_df_we_i`, in, 2: data FIFO write enables.
- `m_af_afull_o`, out, 2: address FIFO almost-full, per requester.
- `m_df_afull_o`, out, 2: data FIFO almost-full, per requester.
- `m_data_o`, out, `2*DATA_WIDTH`: read data, broadcast to both requesters.
- `m_dvalid_o`, out, 2: read data valid, steered per requester.
- `ddr_rd_wr_n_o`, `ddr_addr_o`[30:0], `ddr_data_o`, `ddr_mask_o`, `ddr_af_we_o`, `ddr_df_we_o`: out, to the DDR2 controller.
- `ddr_af_afull_i`, `ddr_df_afull_i`, `ddr_data_i`, `ddr_dvalid_i`, `ddr_phy_rdy_i`: in, from the DDR2 controller.
- `tag_err_o`, out, 1: sticky error flag; data arrived with no outstanding read.

## Operation
- **State machine:** states IDLE, OWN0 and OWN1. A registered `last_owner` bit resets to 1, so requester 0 wins the first arbitration.
- **IDLE:**
  - No transition while `ddr_phy_rdy_i` is 0.
  - Otherwise go to the state of requester `!last_owner` if it is requesting, else to the state of `last_owner` if it is requesting, else stay in IDLE.
  - On entering OWNi, set `last_owner <= i`.
- **OWNi:**
  - `m_granted_o[i]` = 1.
  - Return to IDLE when `m_request_i[i]` = 0. There is no preemption.
  - A requester must finish its write-data pairs before dropping its request.
- **Command path, combinational mux from the owner:**
  - `ddr_af_we_o = m_af_we_i[owner]`, gated by the grant; likewise `ddr_df_we_o`.
  - `ddr_rd_wr_n_o`, `ddr_addr_o`, `ddr_data_o` and `ddr_mask_o` are taken from the owner's slice.
  - In IDLE both enables are 0, `ddr_rd_wr_n_o` = 1, and address/data/mask = 0.
  - Enables from a non-owner are dropped silently.
- **Tag FIFO:**
  - On `ddr_af_we_o && ddr_rd_wr_n_o`, push the owner id into a `TAG_DEPTH`-entry FIFO of 1-bit tags.
- **Read-data steering:**
  - `m_data_o = ddr_data_i`.
  - `m_dvalid_o[t] = ddr_dvalid_i && !tag_empty`, where t is the FIFO head.
  - A beat counter (0..`BEATS_PER_READ-1`) increments on each `ddr_dvalid_i`.
  - On the last beat the counter wraps to 0 and the FIFO head is popped.
  - A push and a pop in the same cycle leave the count unchanged.
- **Back-pressure:**
  - `m_af_afull_o[i] = !m_granted_o[i] | ddr_af_afull_i | (tag_count >= TAG_DEPTH-2)`.
  - `m_df_afull_o[i] = !m_granted_o[i] | ddr_df_afull_i`.
- **Errors:**
  - `ddr_dvalid_i` with the tag FIFO empty sets `tag_err_o`, which holds until reset. No pop and no `m_dvalid_o`.
  - A push into a full tag FIFO also sets `tag_err_o`; the tag is dropped.

## Timing
- **Reset:** values take effect at the first `clk` edge with `reset_n` = 0:
  - state IDLE, `last_owner` = 1;
  - tag FIFO empty, beat counter 0;
  - `m_granted_o` = 0, `tag_err_o` = 0;
  - all ddr enables 0.
- **Reset mid-operation:** reset discards outstanding tags. The controller must be reset together with the arbiter.
- **Grant latency:** one cycle from a request seen in IDLE to `m_granted_o`.
- **Handover gap:** a request drop returns to IDLE, so there is a minimum of one idle cycle between owners.
- **Datapath latency:** the command and read-data paths are purely combinational (zero latency). `m_dvalid_o` is aligned with `ddr_data_i`.
- **Simultaneous requests in IDLE:** the non-last owner wins.
- **Release without competition:** a requester that drops and re-raises its request while the other is idle regains ownership after one IDLE cycle.
- **Phy readiness:** `ddr_phy_rdy_i` falling during OWNi does not revoke the grant.

## Test plan
- **Reset:** hold `reset_n` = 0 for 5 cycles with both requests high -> `m_granted_o` = 00 throughout. After release with `ddr_phy_rdy_i` = 1, `m_granted_o` = 01 one cycle later.
- **Round-robin:** both requests held; requester 0 drops after 4 cycles -> one IDLE cycle, then `m_granted_o` = 10. Requester 1 drops -> `m_granted_o` = 01.
- **Read steering:**
  - Requester 0 issues 2 reads, releases; requester 1 issues 1 read.
  - Controller returns 6 `ddr_dvalid_i` beats.
  - Required: `m_dvalid_o` = 01 for the first 4 beats, then 10 for 2 beats; `tag_count` returns to 0.
- **Gating:** a non-owner pulses `m_af_we_i` with address 0x100 -> `ddr_af_we_o` stays 0 and no tag is pushed.
- **Tag-FIFO back-pressure:** issue 14 reads with no data returned -> `m_af_afull_o[owner]` = 1 once `tag_count` reaches 14. One returned read (2 beats) deasserts it.
- **Errors:** `ddr_dvalid_i` pulse with an empty tag FIFO -> `tag_err_o` = 1 next cycle and stays 1 until reset; `m_dvalid_o` = 00.
